// File: rtl/pe_array_reduce_pkg.sv
// Shared opcode set and latency helper for the PE execute stage; no logic, no latency.
// Used by the fetch unit to schedule result-RAM writes.
package pe_array_reduce_pkg;

    typedef enum logic [3:0] {
        OP_NOOP = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DOTP = 4'd4
    } pe_op_e;

    localparam int PE_OP_W = 4;

    // accept-to-out_valid cycles: lane ALU reg + tree levels + ACC reg + output reg, minus the accept edge
    function automatic int pe_lat_f(input int lanes);
        return $clog2(lanes) + 2;
    endfunction

endpackage

// File: rtl/pe_array_reduce_if.sv
// Operand/opcode bus from the fetch unit and result bus to the RAM writer, both valid/ready.
// master = upstream source / downstream sink side, slave = the execute stage.
interface pe_array_reduce_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int LANES        = 4,
    parameter int ACC_WIDTH    = DATA_WIDTH + 8,
    parameter int OPCODE_WIDTH = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [OPCODE_WIDTH-1:0]       in_op;
    logic                          in_acc_clr;
    logic                          in_last;
    logic [LANES*DATA_WIDTH-1:0]   in_a;
    logic [LANES*DATA_WIDTH-1:0]   in_b;
    logic                          out_valid;
    logic                          out_ready;
    logic [OPCODE_WIDTH-1:0]       out_op;
    logic [LANES*DATA_WIDTH-1:0]   out_vec;
    logic [ACC_WIDTH-1:0]          out_scalar;

    modport master (
        output in_valid, in_op, in_acc_clr, in_last, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_vec, out_scalar
    );

    modport slave (
        input  in_valid, in_op, in_acc_clr, in_last, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_vec, out_scalar
    );
endinterface

// File: rtl/pe_array_reduce_adder_tree.sv
// Registered binary adder tree with a sideband that travels alongside; latency $clog2(LANES), 0 = passthrough.
// Each level holds only while valid and blocked downstream, so bubbles collapse; o_rdy = first level can load.
module pe_adder_tree #(
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 40,
    parameter int SB_W      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_vld,
    input  logic [LANES*ACC_WIDTH-1:0] i_lanes,
    input  logic [SB_W-1:0]            i_sb,
    input  logic                       i_en,
    output logic                       o_rdy,
    output logic                       o_vld,
    output logic [ACC_WIDTH-1:0]       o_sum,
    output logic [SB_W-1:0]            o_sb
);
    localparam int LVLS = $clog2(LANES);
    localparam int PAD  = 1 << LVLS;

    genvar l, j;
    generate
        for (l = 1; l <= LVLS; l++) begin : g_lvl
            localparam int N = PAD >> l;
            logic [ACC_WIDTH-1:0] w_kid [2*N];
            logic [ACC_WIDTH-1:0] r_sum [N];
            logic                 r_vld;
            logic [SB_W-1:0]      r_sb;
            logic                 w_vld_in;
            logic [SB_W-1:0]      w_sb_in;
            logic                 w_en;

            if (l == 1) begin : g_leaf
                // lanes beyond LANES pad the tree with zeros
                for (j = 0; j < 2*N; j++) begin : g_pad
                    if (j < LANES) begin : g_lane
                        assign w_kid[j] = i_lanes[j*ACC_WIDTH +: ACC_WIDTH];
                    end else begin : g_zero
                        assign w_kid[j] = '0;
                    end
                end
                assign w_vld_in = i_vld;
                assign w_sb_in  = i_sb;
            end else begin : g_inner
                assign w_kid    = g_lvl[l-1].r_sum;
                assign w_vld_in = g_lvl[l-1].r_vld;
                assign w_sb_in  = g_lvl[l-1].r_sb;
            end

            if (l == LVLS) begin : g_tail
                assign w_en = ~r_vld | i_en;
            end else begin : g_mid
                assign w_en = ~r_vld | g_lvl[l+1].w_en;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_sb  <= '0;
                    for (int k = 0; k < N; k++) r_sum[k] <= '0;
                end else if (w_en) begin
                    r_vld <= w_vld_in;
                    r_sb  <= w_sb_in;
                    for (int k = 0; k < N; k++) r_sum[k] <= w_kid[2*k] + w_kid[2*k+1];
                end
            end
        end

        if (LVLS == 0) begin : g_pass
            assign o_rdy = i_en;
            assign o_vld = i_vld;
            assign o_sum = i_lanes[ACC_WIDTH-1:0];
            assign o_sb  = i_sb;
        end else begin : g_out
            assign o_rdy = g_lvl[1].w_en;
            assign o_vld = g_lvl[LVLS].r_vld;
            assign o_sum = g_lvl[LVLS].r_sum[0];
            assign o_sb  = g_lvl[LVLS].r_sb;
        end
    endgenerate
endmodule

// File: rtl/pe_array_reduce.sv
// SIMD execute stage: per-lane ADD/SUB/MUL and multi-beat DOTP into a running accumulator; latency $clog2(LANES)+2 for all ops.
// Backpressure: in_ready = ~(out_valid & ~out_ready); stalled stages hold, empty stages keep filling.
module pe_array_reduce
    import pe_array_reduce_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int LANES        = 4,
    parameter int ACC_WIDTH    = DATA_WIDTH + 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    pe_array_reduce_if.slave bus
);
    localparam int VEC_W = LANES * DATA_WIDTH;
    localparam int SB_W  = PE_OP_W + 2 + VEC_W;

    pe_op_e               w_op;
    logic [VEC_W-1:0]     w_lane_res;
    logic [LANES*ACC_WIDTH-1:0] w_tree_in;
    logic                 w_tree_rdy, w_t_vld, w_t_clr, w_t_last;
    logic [ACC_WIDTH-1:0] w_t_sum;
    logic [SB_W-1:0]      w_t_sb;
    pe_op_e               w_t_op;
    logic [VEC_W-1:0]     w_t_vec;
    logic                 w_s0_en, w_acc_en, w_out_en, w_emit;

    logic                 r_s0_vld, r_s0_clr, r_s0_last;
    pe_op_e               r_s0_op;
    logic [VEC_W-1:0]     r_s0_vec;
    logic                 r_acc_vld, r_acc_last;
    pe_op_e               r_acc_op;
    logic [VEC_W-1:0]     r_acc_vec;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_out_vld;
    pe_op_e               r_out_op;
    logic [VEC_W-1:0]     r_out_vec;
    logic [ACC_WIDTH-1:0] r_out_scalar;

    always_comb begin
        w_op = OP_NOOP;
        case (bus.in_op)
            OPCODE_WIDTH'(OP_ADD):  w_op = OP_ADD;
            OPCODE_WIDTH'(OP_SUB):  w_op = OP_SUB;
            OPCODE_WIDTH'(OP_MUL):  w_op = OP_MUL;
            OPCODE_WIDTH'(OP_DOTP): w_op = OP_DOTP;
            default:                w_op = OP_NOOP;
        endcase
    end

    assign w_out_en     = ~r_out_vld | bus.out_ready;
    assign w_acc_en     = ~r_acc_vld | w_out_en;
    assign w_s0_en      = ~r_s0_vld | w_tree_rdy;
    assign bus.in_ready = ~(r_out_vld & ~bus.out_ready);

    // DOTP reuses the lane multiplier; its products ride the vector path into the tree
    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_a, w_b, w_prod;
            assign w_a    = bus.in_a[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_b    = bus.in_b[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_prod = w_a * w_b;
            assign w_lane_res[g*DATA_WIDTH +: DATA_WIDTH] =
                (w_op == OP_ADD) ? w_a + w_b :
                (w_op == OP_SUB) ? w_a - w_b :
                (w_op == OP_MUL || w_op == OP_DOTP) ? w_prod : '0;
            assign w_tree_in[g*ACC_WIDTH +: ACC_WIDTH] =
                ACC_WIDTH'($signed(r_s0_vec[g*DATA_WIDTH +: DATA_WIDTH]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld  <= 1'b0;
            r_s0_op   <= OP_NOOP;
            r_s0_clr  <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_vec  <= '0;
        end else if (w_s0_en) begin
            r_s0_vld  <= bus.in_valid & bus.in_ready;
            r_s0_op   <= w_op;
            r_s0_clr  <= bus.in_acc_clr & (w_op == OP_DOTP);
            r_s0_last <= bus.in_last & (w_op == OP_DOTP);
            r_s0_vec  <= w_lane_res;
        end
    end

    pe_adder_tree #(.LANES(LANES), .ACC_WIDTH(ACC_WIDTH), .SB_W(SB_W)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (r_s0_vld),
        .i_lanes (w_tree_in),
        .i_sb    ({r_s0_op, r_s0_clr, r_s0_last, r_s0_vec}),
        .i_en    (w_acc_en),
        .o_rdy   (w_tree_rdy),
        .o_vld   (w_t_vld),
        .o_sum   (w_t_sum),
        .o_sb    (w_t_sb)
    );

    assign w_t_op   = pe_op_e'(w_t_sb[SB_W-1 -: PE_OP_W]);
    assign w_t_clr  = w_t_sb[VEC_W+1];
    assign w_t_last = w_t_sb[VEC_W];
    assign w_t_vec  = w_t_sb[VEC_W-1:0];

    // acc moves only when a DOTP beat enters this stage, so stalls and other ops leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_vld  <= 1'b0;
            r_acc_op   <= OP_NOOP;
            r_acc_last <= 1'b0;
            r_acc_vec  <= '0;
            r_acc      <= '0;
        end else if (w_acc_en) begin
            r_acc_vld  <= w_t_vld;
            r_acc_op   <= w_t_op;
            r_acc_last <= w_t_last;
            r_acc_vec  <= w_t_vec;
            if (w_t_vld && w_t_op == OP_DOTP)
                r_acc <= (w_t_clr ? '0 : r_acc) + w_t_sum;
        end
    end

    assign w_emit = r_acc_vld & ((r_acc_op == OP_ADD) | (r_acc_op == OP_SUB) | (r_acc_op == OP_MUL) |
                                 ((r_acc_op == OP_DOTP) & r_acc_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld    <= 1'b0;
            r_out_op     <= OP_NOOP;
            r_out_vec    <= '0;
            r_out_scalar <= '0;
        end else if (w_out_en) begin
            r_out_vld <= w_emit;
            if (w_emit) begin
                r_out_op     <= r_acc_op;
                r_out_vec    <= (r_acc_op == OP_DOTP) ? '0 : r_acc_vec;
                r_out_scalar <= (r_acc_op == OP_DOTP) ? r_acc : '0;
            end
        end
    end

    assign bus.out_valid  = r_out_vld;
    assign bus.out_op     = OPCODE_WIDTH'(r_out_op);
    assign bus.out_vec    = r_out_vec;
    assign bus.out_scalar = r_out_scalar;
endmodule
